// File: rtl/res_arb_pkg.sv
// Shared definitions for the result-memory port arbiter: memory geometry,
// requester identifiers and the arbiter state encoding.
package res_arb_pkg;

    localparam int ADDR_W = 14;  // {row[6:0], col[6:0]}
    localparam int DATA_W = 8;

    localparam int REQ_FWD  = 0;
    localparam int REQ_BWD  = 1;
    localparam int REQ_HOST = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/res_arb_rr_pick.sv
// Combinational rotating-priority picker: starting at ptr and wrapping
// modulo N, returns the first asserted request as a one-hot grant plus its
// binary index. Also used by the host-side scheduler.
module res_arb_rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N candidates upward from ptr; the first hit wins.
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = IW'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/res_port_arbiter.sv
// Result-memory port arbiter: shares one res_rd/res_wr/res_addr/res_do/res_di
// port between the forward engine, backward engine and host read-out.
// One access per cycle, round-robin arbitration, optional lock so a
// read/modify/write sequence from one engine is never interleaved.
// Build option: RES_ARB_FIXED_PRIO_EN ties the pointer to 0 (fixed priority,
// index 0 highest); locking is unaffected.
module res_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = res_arb_pkg::ADDR_W,
    parameter int DATA_W   = res_arb_pkg::DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      res_rd,
    output logic                      res_wr,
    output logic [ADDR_W-1:0]         res_addr,
    output logic [DATA_W-1:0]         res_do,
    input  logic [DATA_W-1:0]         res_di
);

    import res_arb_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t    state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [IW-1:0] ptr, ptr_nx;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic [IW-1:0] acc_idx;
    logic          acc;

    // Read-return tracking: one stage per cycle of memory latency.
    logic [READ_LAT-1:0] vld_p;
    logic [IW-1:0]       own_p [READ_LAT];

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) >= NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    res_arb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant: rotating pick in ARB, owner only while LOCKED, nothing in reset.
    always_comb begin
        req_ready = '0;
        acc_idx   = pick_idx;
        if (state == LOCKED) begin
            acc_idx          = owner;
            req_ready[owner] = req_valid[owner];
        end else if (pick_any) begin
            req_ready = pick_grant;
        end
        if (reset) begin
            req_ready = '0;
        end
    end

    assign acc = |(req_valid & req_ready);

    // Next state, lock owner and round-robin pointer.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        case (state)
            ARB: begin
                if (acc) begin
                    if (req_lock[acc_idx]) begin
                        state_nx = LOCKED;
                        owner_nx = acc_idx;
                    end else begin
                        ptr_nx = next_idx(acc_idx);
                    end
                end
            end
            LOCKED: begin
                // Owner idle, or its last access of the sequence drops the lock.
                if (!req_valid[owner] || !req_lock[owner]) begin
                    state_nx = ARB;
                    ptr_nx   = next_idx(owner);
                end
            end
            default: state_nx = ARB;
        endcase
`ifdef RES_ARB_FIXED_PRIO_EN
        ptr_nx = '0;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
            owner <= '0;
            ptr   <= IW'(REQ_FWD);
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
        end
    end

    // Stage p0: register the accepted access onto the memory pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_rd   <= 1'b0;
            res_wr   <= 1'b0;
            res_addr <= '0;
            res_do   <= '0;
        end else begin
            res_rd <= acc && !req_we[acc_idx];
            res_wr <= acc && req_we[acc_idx];
            if (acc) begin
                res_addr <= req_addr[acc_idx*ADDR_W +: ADDR_W];
                res_do   <= req_wdata[acc_idx*DATA_W +: DATA_W];
            end
        end
    end

    // Stages p0..p(READ_LAT-1): carry read owner ids alongside the memory latency;
    // final stage captures res_di and raises the owner's rsp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int k = 0; k < READ_LAT; k++) begin
                own_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= acc && !req_we[acc_idx];
            own_p[0] <= acc_idx;
            for (int k = 1; k < READ_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                own_p[k] <= own_p[k-1];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] <= vld_p[READ_LAT-1] && (int'(own_p[READ_LAT-1]) == i);
            end
            rsp_data <= vld_p[READ_LAT-1] ? res_di : '0;
        end
    end

endmodule

// File: tb/tb_res_port_arbiter.sv
// Scoreboard bench for res_port_arbiter: directed stimulus pushes expected
// memory accesses and read responses; a negedge monitor pops and compares.
module tb_res_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 14;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            res_rd;
    logic            res_wr;
    logic [AW-1:0]   res_addr;
    logic [DW-1:0]   res_do;
    logic [DW-1:0]   res_di;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct packed {
        logic [N-1:0]  own;
        logic [DW-1:0] data;
    } rsp_t;

    acc_t acc_q [$];
    rsp_t rsp_q [$];
    acc_t e_acc;
    rsp_t e_rsp;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [DW-1:0] mem [0:16383];

    res_port_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .READ_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .res_rd    (res_rd),
        .res_wr    (res_wr),
        .res_addr  (res_addr),
        .res_do    (res_do),
        .res_di    (res_di)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at the clock edge.
    assign res_di = mem[res_addr];

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0081] = 8'h05;
        mem[14'h0010] = 8'h11;
        mem[14'h0020] = 8'h22;
        mem[14'h0030] = 8'h33;
        mem[14'h0102] = 8'h44;
        forever begin
            @(posedge clk);
            if (res_wr === 1'b1) mem[res_addr] = res_do;
        end
    end

    // Monitor: compare every pin access and every read response.
    always @(negedge clk) begin
        if (res_rd === 1'b1 || res_wr === 1'b1) begin
            checks++;
            if (acc_q.size() == 0) begin
                errors++;
                $display("FAIL access: unexpected rd=%0b wr=%0b addr=%h", res_rd, res_wr, res_addr);
            end else begin
                e_acc = acc_q.pop_front();
                if (res_wr !== e_acc.we || res_rd !== !e_acc.we || res_addr !== e_acc.addr ||
                    (e_acc.we && res_do !== e_acc.data)) begin
                    errors++;
                    $display("FAIL access: got wr=%0b rd=%0b addr=%h do=%h, want we=%0b addr=%h do=%h",
                             res_wr, res_rd, res_addr, res_do, e_acc.we, e_acc.addr, e_acc.data);
                end
            end
        end
        if ((|rsp_valid) === 1'b1) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL response: unexpected rsp_valid=%b data=%h", rsp_valid, rsp_data);
            end else begin
                e_rsp = rsp_q.pop_front();
                if (rsp_valid !== e_rsp.own || rsp_data !== e_rsp.data) begin
                    errors++;
                    $display("FAIL response: got valid=%b data=%h, want valid=%b data=%h",
                             rsp_valid, rsp_data, e_rsp.own, e_rsp.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; checks the grant and queues expected results.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lk,
                        input logic [N-1:0] exp_rdy, input logic [DW-1:0] exp_rd, input bit want_rsp);
        logic [N-1:0] oh;
        @(posedge clk);
        #1;
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a[2], a[1], a[0]};
        req_wdata = {d[2], d[1], d[0]};
        #2;
        chk("grant", {29'd0, req_ready}, {29'd0, exp_rdy});
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                acc_q.push_back('{we: we[i], addr: a[i], data: d[i]});
                if (!we[i] && want_rsp) begin
                    oh = '0;
                    oh[i] = 1'b1;
                    rsp_q.push_back('{own: oh, data: exp_rd});
                end
            end
        end
    endtask

    task automatic idle();
        step(3'b000, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, {29'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {29'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_res_rd"}, {31'd0, res_rd}, 32'd0);
        chk({tag, "_res_wr"}, {31'd0, res_wr}, 32'd0);
        chk({tag, "_res_addr"}, {18'd0, res_addr}, 32'd0);
        chk({tag, "_res_do"}, {24'd0, res_do}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a[0] = 14'h0010; a[1] = 14'h0020; a[2] = 14'h0030;
        d[0] = 8'h00;    d[1] = 8'h00;    d[2] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        chk_zero("reset");

        // Round robin: all three reading, no lock
        repeat (2) begin
            step(3'b111, 3'b000, 3'b000, 3'b001, 8'h11, 1'b1);
            step(3'b111, 3'b000, 3'b000, 3'b010, 8'h22, 1'b1);
            step(3'b111, 3'b000, 3'b000, 3'b100, 8'h33, 1'b1);
        end
        idle();

        // Single read with exact latency
        a[0] = 14'h0081;
        step(3'b001, 3'b000, 3'b000, 3'b001, 8'h05, 1'b1);
        idle();
        @(negedge clk);
        chk("single_res_rd", {31'd0, res_rd}, 32'd1);
        chk("single_res_addr", {18'd0, res_addr}, 32'h0081);
        chk("single_rsp_early", {29'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("single_rsp_valid", {29'd0, rsp_valid}, 32'b001);
        chk("single_rsp_data", {24'd0, rsp_data}, 32'd5);
        a[0] = 14'h0010;

        // Ordering: write then read same address from another requester
        a[0] = 14'h0203; d[0] = 8'h09;
        step(3'b001, 3'b001, 3'b000, 3'b001, 8'h00, 1'b0);
        a[2] = 14'h0203;
        step(3'b100, 3'b000, 3'b000, 3'b100, 8'h09, 1'b1);
        idle();
        a[0] = 14'h0010; d[0] = 8'h00; a[2] = 14'h0030;

        // Lock: requester 1 holds the port for 6 accesses
        step(3'b010, 3'b000, 3'b010, 3'b010, 8'h22, 1'b1);
        repeat (4) step(3'b111, 3'b000, 3'b010, 3'b010, 8'h22, 1'b1);
        a[1] = 14'h0102; d[1] = 8'h07;
        step(3'b111, 3'b010, 3'b000, 3'b010, 8'h00, 1'b0);
        a[1] = 14'h0020; d[1] = 8'h00;
        step(3'b111, 3'b000, 3'b000, 3'b100, 8'h33, 1'b1);
        idle();

        // Lock drop: owner idles for a cycle, lock released
        step(3'b001, 3'b000, 3'b001, 3'b001, 8'h11, 1'b1);
        step(3'b110, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
        step(3'b111, 3'b000, 3'b000, 3'b010, 8'h22, 1'b1);
        idle();

        // Reset mid-read: read accepted, then reset; no response may follow
        step(3'b010, 3'b000, 3'b000, 3'b010, 8'h22, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        #2;
        chk_zero("midrd");
        idle();
        idle();
        step(3'b111, 3'b000, 3'b000, 3'b001, 8'h11, 1'b1);
        repeat (4) idle();

        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/res_port_arbiter.md
Name: res_port_arbiter

Overview:
Shares the single result-memory port (14-bit address, 8-bit data) between several pixel engines: forward-pass engine, backward-pass engine and host read-out.
- Issues at most one access per cycle, using round-robin arbitration.
- Supports a lock so that one engine's multi-neighbour read/modify/write sequence is not interleaved with another engine's accesses.
- Sits between the engines and the res_rd/res_wr/res_addr/res_do/res_di memory pins.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = forward, 1 = backward, 2 = host)
ADDR_W, 14, memory address width ({row[6:0], col[6:0]})
DATA_W, 8, memory data width
READ_LAT, 1, cycles from res_rd high on the pins to valid res_di (1..3)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester access request
req_we  input  NUM_REQ  1 = write, 0 = read
req_lock  input  NUM_REQ  keep grant after this access
req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice i
req_wdata  input  NUM_REQ*DATA_W  flattened write data
req_ready  output  NUM_REQ  one-hot grant; access accepted when valid&&ready
rsp_valid  output  NUM_REQ  one-hot read-data-valid strobe
rsp_data  output  DATA_W  read data, shared by all requesters
res_rd  output  1  memory read strobe
res_wr  output  1  memory write strobe
res_addr  output  ADDR_W  memory address
res_do  output  DATA_W  memory write data
res_di  input  DATA_W  memory read data

Behaviour:
- Reset (sync, at the clock edge with reset=1):
  - req_ready=0, rsp_valid=0, res_rd=0, res_wr=0, res_addr=0, res_do=0, rsp_data=0.
  - Round-robin pointer=0, state=ARB, response pipeline cleared.
  - Any in-flight read is discarded and no rsp_valid follows.
- req_ready is combinational from the current state, the pointer and req_valid; at most one bit is high.
- State ARB:
  - Grant the first i with req_valid[i]=1, searching upward from the pointer and wrapping modulo NUM_REQ.
  - No valid request -> req_ready=0.
- Acceptance in cycle t (req_valid[i] && req_ready[i]):
  - At t+1: res_addr/res_do/res_wr/res_rd are registered from requester i; res_wr=req_we[i], res_rd=!req_we[i].
  - Strobes last exactly one cycle unless another access is accepted in cycle t+1.
- Read returns:
  - rsp_valid[i]=1 at cycle t+1+READ_LAT.
  - rsp_data is registered res_di; both are held for one cycle only.
  - Owner IDs travel through a READ_LAT+1 deep shift pipeline, so back-to-back reads from different requesters return in issue order.
- Throughput: 1 access/cycle sustained. Accesses are never reordered, so a write followed by a read to the same address returns the new value.
- Pointer update: after an accepted access with req_lock=0, pointer=(i+1) mod NUM_REQ.
- Accepted access with req_lock[i]=1 -> state LOCKED(owner=i); pointer unchanged.
- State LOCKED:
  - req_ready[owner]=req_valid[owner]; all other ready bits are 0.
  - Return to ARB, with pointer=owner+1, on either:
    - an accepted owner access with req_lock=0, or
    - a cycle with req_valid[owner]=0.
- A write issued with req_lock=1 behaves identically to a read with lock.
- Reset asserted during LOCKED returns the arbiter to ARB with pointer 0.

Optional Feature:
Macro RES_ARB_FIXED_PRIO_EN.
- Defined: the pointer is tied to 0, giving fixed priority with index 0 highest. LOCKED behaviour is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package res_arb_pkg holds:
  - ADDR_W/DATA_W constants
  - requester IDs REQ_FWD=0, REQ_BWD=1, REQ_HOST=2
  - state enum {ARB, LOCKED}
- One sub-module: res_arb_rr_pick, a combinational rotating-priority picker (req vector, pointer -> one-hot grant plus binary index). It is reused by the host-side scheduler.

Test Plan:
- Single read: requester 0 reads addr 0x0081 with mem[0x0081]=5 at t=0 -> res_rd=1, res_addr=0x0081 at t=1; rsp_valid=3'b001, rsp_data=5 at t=2 (READ_LAT=1).
- Round robin: all three requesters hold req_valid with lock=0 for 6 cycles -> grants in order 0,1,2,0,1,2, with one res_rd/res_wr per cycle.
- Lock: requester 1 issues 5 reads with lock=1 and then a write of 7 to 0x0102 with lock=0, while requesters 0 and 2 request throughout -> only requester 1 is granted for those 6 accesses, then requester 2 is granted next.
- Lock drop: requester 0 locks, then deasserts req_valid for one cycle -> the lock is released and requester 1 is granted in the following cycle.
- Ordering: requester 0 writes 9 to 0x0203, then requester 2 reads 0x0203 in the next cycle -> rsp_valid=3'b100, rsp_data=9.
- Reset mid-read: reset is asserted in the cycle after a read is accepted -> no rsp_valid afterwards, all outputs 0, and the first post-reset grant goes to requester 0.
